// File: rtl/rns_9_8_7_pkg.sv
// Shared constants and bundles for the 9/8/7 residue number system blocks.
// Range checking is enabled in the top block by BIN_TO_RNS_RANGE_CHECK_EN.
package rns_9_8_7_pkg;

  localparam int M1    = 9;
  localparam int M2    = 8;
  localparam int M3    = 7;
  localparam int RANGE = M1 * M2 * M3;

  localparam int W1 = 4;
  localparam int W2 = 3;
  localparam int W3 = 3;
  localparam int WX = 9;

  localparam int WS9 = 7;
  localparam int WS7 = 5;

  typedef struct packed {
    logic [WS9-1:0] s9;
    logic [WS7-1:0] s7;
    logic [W2-1:0]  r2;
  } fold_t;

  typedef struct packed {
    logic [W1-1:0] r1;
    logic [W2-1:0] r2;
    logic [W3-1:0] r3;
  } rns_triple_t;

endpackage

// File: rtl/rns_fold_reduce.sv
// Final reduction of a partially folded value for one modulus M.
// Needs 2^K mod M == 1 so the upper part adds straight onto the lower.
module rns_fold_reduce #(
  parameter int M    = 9,
  parameter int WI   = 7,
  parameter int K    = 6,
  parameter int WO   = 4,
  parameter int NSUB = 7
) (
  input  logic [WI-1:0] s_in,
  output logic [WO-1:0] r_out
);

  localparam int WF = K + 1;

  logic [WF-1:0] f;

  // All candidate subtractions are compared in parallel; the largest
  // multiple of M not exceeding f selects the result.
  always_comb begin
    f     = WF'(s_in[WI-1:K]) + WF'(s_in[K-1:0]);
    r_out = WO'(f);
    for (int i = 1; i <= NSUB; i++) begin
      if (f >= WF'(i * M)) begin
        r_out = WO'(f - WF'(i * M));
      end
    end
  end

endmodule

// File: rtl/bin_to_rns_9_8_7.sv
// Two-stage elastic binary to residue (mod 9, 8, 7) converter.
// Optional range_err_out port under BIN_TO_RNS_RANGE_CHECK_EN.
module bin_to_rns_9_8_7
  import rns_9_8_7_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [WX-1:0] x_in,
  input  logic          valid_in,
  output logic          ready_out,
  output logic [W1-1:0] r1_out,
  output logic [W2-1:0] r2_out,
  output logic [W3-1:0] r3_out,
  output logic          valid_out,
  input  logic          ready_in
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  ,
  output logic          range_err_out
`endif
);

  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  fold_t       fold_q, fold_d;
  rns_triple_t res_q, res_d;
  logic        en1, en2;
  logic [W1-1:0] red9;
  logic [W3-1:0] red7;

  assign en2       = ~v2_q | ready_in;
  assign en1       = ~v1_q | en2;
  assign ready_out = en1;

  rns_fold_reduce #(
    .M    (M1),
    .WI   (WS9),
    .K    (6),
    .WO   (W1),
    .NSUB (7)
  ) u_red9 (
    .s_in  (fold_q.s9),
    .r_out (red9)
  );

  rns_fold_reduce #(
    .M    (M3),
    .WI   (WS7),
    .K    (3),
    .WO   (W3),
    .NSUB (1)
  ) u_red7 (
    .s_in  (fold_q.s7),
    .r_out (red7)
  );

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    fold_d = fold_q;
    res_d  = res_q;
    if (en1) begin
      v1_d      = valid_in;
      fold_d.s9 = WS9'(x_in[8:6]) + WS9'(x_in[5:0]);
      fold_d.s7 = WS7'(x_in[8:6]) + WS7'(x_in[5:3])
                + WS7'(x_in[2:0]);
      fold_d.r2 = x_in[2:0];
    end
    if (en2) begin
      v2_d     = v1_q;
      res_d.r1 = red9;
      res_d.r2 = fold_q.r2;
      res_d.r3 = red7;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      fold_q <= '0;
      res_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      fold_q <= fold_d;
      res_q  <= res_d;
    end
  end

  assign r1_out    = res_q.r1;
  assign r2_out    = res_q.r2;
  assign r3_out    = res_q.r3;
  assign valid_out = v2_q;

`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  logic err1_q, err1_d;
  logic err2_q, err2_d;

  always_comb begin
    err1_d = err1_q;
    err2_d = err2_q;
    if (en1) err1_d = (32'(x_in) >= RANGE);
    if (en2) err2_d = err1_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      err1_q <= err1_d;
      err2_q <= err2_d;
    end
  end

  assign range_err_out = err2_q;
`endif

endmodule

// File: tb/tb_bin_to_rns_9_8_7.sv
// Directed and scoreboarded bench for bin_to_rns_9_8_7.
// Define BIN_TO_RNS_RANGE_CHECK_EN to also check range_err_out.
module tb_bin_to_rns_9_8_7;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [8:0] x_in;
  logic       valid_in;
  logic       ready_out;
  logic [3:0] r1_out;
  logic [2:0] r2_out;
  logic [2:0] r3_out;
  logic       valid_out;
  logic       ready_in;
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  logic       range_err_out;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int q[$];
  int cyc_n     = 0;
  int n_out     = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  logic prev_stall = 1'b0;

  always #5 clk_in = ~clk_in;

  bin_to_rns_9_8_7 dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .x_in          (x_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .r1_out        (r1_out),
    .r2_out        (r2_out),
    .r3_out        (r3_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in)
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    ,
    .range_err_out (range_err_out)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_triple(input string tag, input int x);
    chk({tag, "_r1"}, int'(r1_out), x % 9);
    chk({tag, "_r2"}, int'(r2_out), x % 8);
    chk({tag, "_r3"}, int'(r3_out), x % 7);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    chk({tag, "_err"}, int'(range_err_out), (x >= 504) ? 1 : 0);
`endif
  endtask

  // One clock cycle under scoreboard control; called at a negedge.
  task automatic cyc(input logic vi, input int x, input logic ri);
    valid_in = vi;
    x_in     = 9'(x);
    ready_in = ri;
    #1;
    if (prev_stall) chk("hold_valid", int'(valid_out), 1);
    if (valid_out) begin
      if (q.size() == 0) begin
        chk("spurious_out", int'(valid_out), 0);
      end else begin
        chk_triple("sb", q[0]);
        if (ri) begin
          void'(q.pop_front());
          n_out++;
          if (first_cyc < 0) first_cyc = cyc_n;
          last_cyc = cyc_n;
        end
      end
    end
    if (vi && ready_out) q.push_back(x);
    prev_stall = valid_out && !ri;
    @(negedge clk_in);
    cyc_n++;
  endtask

  initial begin
    rst_n_in = 1'b0;
    x_in     = '0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_r1", int'(r1_out), 0);
    chk("rst_r2", int'(r2_out), 0);
    chk("rst_r3", int'(r3_out), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    chk("rst_err", int'(range_err_out), 0);
`endif
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    chk("rel_ready", int'(ready_out), 1);

    // zero operand, latency 2
    valid_in = 1'b1;
    x_in     = 9'd0;
    ready_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    #1;
    chk("zero_lat1_valid", int'(valid_out), 0);
    @(negedge clk_in);
    #1;
    chk("zero_valid", int'(valid_out), 1);
    chk("zero_r1", int'(r1_out), 0);
    chk("zero_r2", int'(r2_out), 0);
    chk("zero_r3", int'(r3_out), 0);
    @(negedge clk_in);
    #1;
    chk("zero_drain", int'(valid_out), 0);

    // 503 then 255 back to back
    valid_in = 1'b1;
    x_in     = 9'd503;
    @(negedge clk_in);
    x_in = 9'd255;
    @(negedge clk_in);
    valid_in = 1'b0;
    #1;
    chk("b2b_a_valid", int'(valid_out), 1);
    chk("b2b_a_r1", int'(r1_out), 8);
    chk("b2b_a_r2", int'(r2_out), 7);
    chk("b2b_a_r3", int'(r3_out), 6);
    @(negedge clk_in);
    #1;
    chk("b2b_b_valid", int'(valid_out), 1);
    chk("b2b_b_r1", int'(r1_out), 3);
    chk("b2b_b_r2", int'(r2_out), 7);
    chk("b2b_b_r3", int'(r3_out), 3);
    @(negedge clk_in);
    #1;
    chk("b2b_drain", int'(valid_out), 0);

    // out-of-range operand 511 then 503
    valid_in = 1'b1;
    x_in     = 9'd511;
    @(negedge clk_in);
    x_in = 9'd503;
    @(negedge clk_in);
    valid_in = 1'b0;
    #1;
    chk("oor_r1", int'(r1_out), 7);
    chk("oor_r2", int'(r2_out), 7);
    chk("oor_r3", int'(r3_out), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    chk("oor_err511", int'(range_err_out), 1);
`endif
    @(negedge clk_in);
    #1;
    chk("oor_503_r1", int'(r1_out), 8);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    chk("oor_err503", int'(range_err_out), 0);
`endif
    @(negedge clk_in);

    // two in flight, 3-cycle stall
    valid_in = 1'b1;
    x_in     = 9'd100;
    ready_in = 1'b1;
    @(negedge clk_in);
    x_in = 9'd200;
    @(negedge clk_in);
    valid_in = 1'b0;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", int'(ready_out), 0);
      chk("stall_valid", int'(valid_out), 1);
      chk("stall_r1", int'(r1_out), 1);
      chk("stall_r2", int'(r2_out), 4);
      chk("stall_r3", int'(r3_out), 2);
      @(negedge clk_in);
    end
    ready_in = 1'b1;
    #1;
    chk("resume_a_r1", int'(r1_out), 1);
    chk("resume_a_valid", int'(valid_out), 1);
    @(negedge clk_in);
    #1;
    chk("resume_b_valid", int'(valid_out), 1);
    chk("resume_b_r1", int'(r1_out), 2);
    chk("resume_b_r2", int'(r2_out), 0);
    chk("resume_b_r3", int'(r3_out), 4);
    @(negedge clk_in);
    #1;
    chk("resume_drain", int'(valid_out), 0);
    @(negedge clk_in);

    // full stream 0..503
    q.delete();
    n_out = 0;
    first_cyc = -1;
    prev_stall = 1'b0;
    for (int v = 0; v < 504; v++) cyc(1'b1, v, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1);
    chk("stream_count", n_out, 504);
    chk("stream_span", last_cyc - first_cyc, 503);
    chk("stream_first_lat", first_cyc, 2);
    chk("stream_left", q.size(), 0);

    // random valid/ready with scoreboard
    n_out = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
          1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 0, 1'b1);
    chk("rand_left", q.size(), 0);
    chk("rand_some_out", (n_out > 20) ? 1 : 0, 1);

    // mid-stream reset discards two in-flight values
    valid_in = 1'b1;
    x_in     = 9'd11;
    ready_in = 1'b1;
    @(negedge clk_in);
    x_in = 9'd22;
    @(negedge clk_in);
    valid_in = 1'b0;
    ready_in = 1'b0;
    #1;
    chk("pre_rst_valid", int'(valid_out), 1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_r1", int'(r1_out), 0);
    chk("mid_rst_r2", int'(r2_out), 0);
    chk("mid_rst_r3", int'(r3_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    chk("post_rst_ready", int'(ready_out), 1);
    q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b1);
    #1;
    chk("post_rst_idle", int'(valid_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
